// File: rtl/div_seq_pkg.sv
// Shared encodings for the sequential divider: FSM states and handshake levels.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider shared by EX: signed/unsigned DIV and MOD, one
// quotient bit per cycle, result returned as {remainder, quotient}.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               neg1_q, neg1_d, neg2_q, neg2_d, sgn_q, sgn_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d, busy_q, busy_d;

    logic [WIDTH:0]     shifted, trial;
    logic [WIDTH-1:0]   rem_fix, quo_fix;
    logic               last_iter;

    assign last_iter = (cnt_q == CNT_W'(WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            sgn_q    <= 1'b0;
            res_q    <= '0;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            sgn_q    <= sgn_d;
            res_q    <= res_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    // Annul wins over everything; start dropping mid-divide is ignored.
    always_comb begin
        state_d = state_q;
        if (annul_i) begin
            state_d = DIV_FREE;
        end else begin
            case (state_q)
                DIV_FREE:   if (start_i == DIV_START)
                                state_d = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                DIV_BYZERO: state_d = DIV_END;
                DIV_ON:     if (last_iter) state_d = DIV_END;
                DIV_END:    if (start_i == DIV_STOP) state_d = DIV_FREE;
                default:    state_d = DIV_FREE;
            endcase
        end
    end

    always_comb begin
        shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? (~quo_q + 1'b1) : quo_q;
        rem_fix = (sgn_q && neg1_q) ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        neg1_d = neg1_q;
        neg2_d = neg2_q;
        sgn_d  = sgn_q;
        res_d  = res_q;

        if (!annul_i) begin
            case (state_q)
                DIV_FREE: if (start_i == DIV_START) begin
                    neg1_d = signed_div_i & opdata1_i[WIDTH-1];
                    neg2_d = signed_div_i & opdata2_i[WIDTH-1];
                    sgn_d  = signed_div_i;
                    dvd_d  = neg1_d ? (~opdata1_i + 1'b1) : opdata1_i;
                    dvs_d  = neg2_d ? (~opdata2_i + 1'b1) : opdata2_i;
                    rem_d  = '0;
                    quo_d  = '0;
                    cnt_d  = '0;
                    res_d  = '0;
                end
                DIV_BYZERO: res_d = '0;
                DIV_ON: begin
                    if (last_iter) begin
                        res_d = {rem_fix, quo_fix};
                    end else begin
                        // Borrow in the top bit means the trial went negative: restore.
                        rem_d = trial[WIDTH] ? shifted : trial;
                        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs lag the state by one edge but drop on the same edge END is left.
    always_comb begin
        ready_d  = (state_q == DIV_END) && (state_d == DIV_END);
        result_d = ready_d ? res_q : '0;
        busy_d   = ((state_q == DIV_ON) || (state_q == DIV_BYZERO)) && !annul_i;
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: driver pushes expected {result, ready cycle}
// into a scoreboard; a monitor pops and compares on each ready_o rising edge.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        start_i, annul_i;
    logic [63:0] result_o;
    logic        ready_o, busy_o;

    div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_chk = 0;
    logic rdy_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every new ready_o must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready_o === 1'b1 && rdy_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_ready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result_o, e.res);
                chk("ready_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        rdy_prev = ready_o;
    end

    // Called at a negedge; the next posedge is the acceptance edge T.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int lat, output int busy_cnt);
        exp_t e;
        bit   done;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        e.res = exp_res;
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        busy_cnt = 0;
        done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
            if (ready_o) done = 1;
        end
        if (!done) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic release_op();
        start_i = 1'b0;
        @(negedge clk);
        chk("release_ready", 64'(ready_o), 64'd0);
        chk("release_result", result_o, 64'd0);
    endtask

    initial begin
        int bc;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_result", result_o, 64'd0);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 100 / 7 unsigned, busy for exactly 33 sampled cycles
        run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, bc);
        chk("busy_cycles", 64'(bc), 64'd33);
        release_op();

        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, bc);
        release_op();
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 34, bc);
        release_op();
        run_op(1'b1, 32'd13, 32'd4, {32'd1, 32'd3}, 34, bc);
        release_op();

        // Divide by zero, both modes
        run_op(1'b0, 32'd1234, 32'd0, 64'd0, 2, bc);
        release_op();
        run_op(1'b1, 32'hFFFF_0000, 32'd0, 64'd0, 2, bc);
        release_op();

        // Annul on the 10th ON cycle; that operation must never report ready
        signed_div_i = 1'b0; opdata1_i = 32'd12345678; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        chk("annul_busy", 64'(busy_o), 64'd0);
        chk("annul_ready", 64'(ready_o), 64'd0);
        annul_i = 1'b0;
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 34, bc);
        release_op();

        // Signed overflow, then hold start for 5 cycles, then reset in END
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 34, bc);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_ready", 64'(ready_o), 64'd1);
            chk("hold_result", result_o, {32'd0, 32'h8000_0000});
        end
        rst = 1'b1; start_i = 1'b0;
        @(negedge clk);
        chk("rst_end_result", result_o, 64'd0);
        chk("rst_end_ready", 64'(ready_o), 64'd0);
        chk("rst_end_busy", 64'(busy_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle 32-bit radix-2 restoring divider with its own sequencing FSM.
- Shared divide resource for the EX stage; handles DIV.W, DIV.WU, MOD.W and MOD.WU.
- EX issues operands with a start/annul handshake and holds its pipeline stall request while start_i=1 and ready_o=0.
- Returns {remainder, quotient} in one 64-bit word.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = signed (two's complement) division, 0 = unsigned.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  divide request (DivStart=1, DivStop=0); held by EX until ready_o is seen.
- annul_i  in  1  cancel the current operation (flush or exception).
- result_o  out  2*WIDTH  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  result valid (DivResultReady=1, DivResultNotReady=0).
- busy_o  out  1  high when the FSM is in ON or BYZERO.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=FREE, cnt=0.
  - result_o=0, ready_o=0, busy_o=0.
  - Internal dividend and divisor registers cleared.
- States: FREE, BYZERO, ON, END. All outputs are registered.
- FREE:
  - Accepts a request when start_i=1 and annul_i=0.
  - Divisor==0 → BYZERO.
  - Otherwise → ON with cnt=0.
  - On acceptance, latch the operand magnitudes: in signed mode, a negative operand is stored as ~x+1. Also latch the two sign bits and signed_div_i.
  - Operands are not re-sampled after acceptance.
- ON:
  - One iteration per cycle using the partial remainder and the latched divisor.
  - Iteration: shift the partial remainder left 1, bringing in the next dividend MSB. Trial-subtract the divisor. If the result is ≥0, keep the difference and set the quotient bit to 1; else restore and set it to 0.
  - After WIDTH iterations (cnt==WIDTH), apply the sign fix-up in the same cycle, then → END:
    - quotient is negated when signed and the signs differ;
    - remainder is negated when signed and the dividend is negative.
- BYZERO: one cycle, result=0, → END.
- END:
  - ready_o=1 and result_o holds the result.
  - Stays in END while start_i=1.
  - start_i=0 → FREE next cycle; ready_o=0 and result_o=0 at that edge.
- annul_i=1 in any state → FREE at the next edge; ready_o=0, result_o=0. annul_i has priority over start_i.
- start_i dropping while in ON or BYZERO is ignored; only annul_i aborts an operation.
- Latency, with start accepted at edge T:
  - normal case: ready_o=1 at edge T+WIDTH+2 (34 cycles);
  - divisor==0: ready_o=1 at edge T+2.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out of the magnitude datapath with wrap; no special casing.
- Back-to-back operations need at least one FREE cycle between results, caused by start_i going low.
- All arithmetic is unsigned on magnitudes. The partial remainder is WIDTH+1 bits to hold the trial-subtract borrow.

Decomposition:
- Add to Defines.v:
  - DivFree, DivByZero, DivOn, DivEnd (2-bit state encodings);
  - DivStart/DivStop;
  - DivResultReady/DivResultNotReady;
  - DoubleRegBus (already used).
- No sub-module: the iteration step is a few lines inside the ON branch.
- EX later wires:
  - div_opdata1_o→opdata1_i, div_opdata2_o→opdata2_i;
  - start_o→start_i, signed_div_o→signed_div_i, cancel_o→annul_i;
  - div_result_i←result_o, div_ready_i←ready_o.

Test Plan:
- Unsigned 100/7, start at edge T:
  - ready_o=1 at T+34 with result_o={0x00000002, 0x0000000E};
  - busy_o=1 for edges T+1..T+33.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero (opdata2_i=0, either mode):
  - ready_o=1 at T+2 with result_o=0;
  - start_i=0 → ready_o=0 next edge.
- Annul mid-divide:
  - annul_i=1 on the 10th ON cycle → FREE, busy_o=0, ready_o never asserts for that operation;
  - a new start 0xFFFFFFFF/1 unsigned, issued right after, completes with quotient 0xFFFFFFFF, remainder 0.
- Overflow and hold:
  - signed 0x80000000/0xFFFFFFFF → {0x00000000, 0x80000000};
  - with start_i held 5 extra cycles, result_o and ready_o stay stable;
  - rst=1 while in END → all outputs 0 next edge.
